// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light phase scheduler.
// State codes double as the externally visible PHASE value.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_A = 3'd2,
    WALK_PH  = 3'd3,
    SIDE_G   = 3'd4,
    SIDE_Y   = 3'd5,
    ALLRED_B = 3'd6
  } tlc_state_e;

  // Lamp vectors are {R,Y,G}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int unsigned TLC_T_GREEN_MIN = 8;
  localparam int unsigned TLC_T_SIDE_MAX  = 10;
  localparam int unsigned TLC_T_YELLOW    = 3;
  localparam int unsigned TLC_T_ALLRED    = 2;
  localparam int unsigned TLC_T_WALK      = 6;
  localparam int unsigned TLC_CW          = 8;

  function automatic logic [2:0] main_lamp(input tlc_state_e s);
    case (s)
      MAIN_G:  main_lamp = LAMP_G;
      MAIN_Y:  main_lamp = LAMP_Y;
      default: main_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input tlc_state_e s);
    case (s)
      SIDE_G:  side_lamp = LAMP_G;
      SIDE_Y:  side_lamp = LAMP_Y;
      default: side_lamp = LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase cycle counter: synchronous clear, saturating increment.
module tlc_phase_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Two-road traffic-light scheduler with pedestrian phase.
// Lamp outputs are registered from the next-state decode so they align with PHASE.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned T_GREEN_MIN = TLC_T_GREEN_MIN,
  parameter int unsigned T_SIDE_MAX  = TLC_T_SIDE_MAX,
  parameter int unsigned T_YELLOW    = TLC_T_YELLOW,
  parameter int unsigned T_ALLRED    = TLC_T_ALLRED,
  parameter int unsigned T_WALK      = TLC_T_WALK,
  parameter int unsigned CW          = TLC_CW
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       SIDE_CAR,
  input  logic       PED_REQ,
  output logic       PED_ACK,
  output logic [2:0] MAIN_LT,
  output logic [2:0] SIDE_LT,
  output logic       WALK,
  output logic [2:0] PHASE
);

  localparam logic [CW-1:0] C_GMIN = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] C_SMAX = CW'(T_SIDE_MAX - 1);
  localparam logic [CW-1:0] C_YEL  = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] C_AR   = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] C_WALK = CW'(T_WALK - 1);

  tlc_state_e    r_state;
  tlc_state_e    w_state_nxt;
  logic [CW-1:0] w_timer;
  logic          w_timer_clr;
  logic          w_ped_set;
  logic          w_walk_exit;
  logic          r_ped_pending;
  logic          r_ped_ack;
  logic [2:0]    r_main_lt;
  logic [2:0]    r_side_lt;
  logic          r_walk;

  tlc_phase_timer #(.CW(CW)) u_timer (
    .i_clk   (CK),
    .i_rst   (RST),
    .i_clear (w_timer_clr),
    .o_count (w_timer)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MAIN_G:   if ((w_timer >= C_GMIN) && (SIDE_CAR || r_ped_pending)) w_state_nxt = MAIN_Y;
      MAIN_Y:   if (w_timer == C_YEL) w_state_nxt = ALLRED_A;
      ALLRED_A: if (w_timer == C_AR) w_state_nxt = r_ped_pending ? WALK_PH : SIDE_G;
      WALK_PH:  if (w_timer == C_WALK) w_state_nxt = SIDE_CAR ? SIDE_G : ALLRED_B;
      SIDE_G:   if ((w_timer == C_SMAX) || ((w_timer >= C_GMIN) && !SIDE_CAR)) w_state_nxt = SIDE_Y;
      SIDE_Y:   if (w_timer == C_YEL) w_state_nxt = ALLRED_B;
      ALLRED_B: if (w_timer == C_AR) w_state_nxt = MAIN_G;
      default:  w_state_nxt = ALLRED_B;
    endcase
  end

  assign w_timer_clr = (w_state_nxt != r_state);
  assign w_walk_exit = (r_state == WALK_PH) && (w_state_nxt != WALK_PH);
  // Requests arriving during the walk phase are ignored until it ends.
  assign w_ped_set   = PED_REQ && !r_ped_pending && (r_state != WALK_PH);

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state       <= ALLRED_B;
      r_ped_pending <= 1'b0;
      r_ped_ack     <= 1'b0;
      r_main_lt     <= LAMP_R;
      r_side_lt     <= LAMP_R;
      r_walk        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_walk_exit) begin
        r_ped_pending <= 1'b0;
      end else if (w_ped_set) begin
        r_ped_pending <= 1'b1;
      end
      r_ped_ack <= w_ped_set;
      r_main_lt <= main_lamp(w_state_nxt);
      r_side_lt <= side_lamp(w_state_nxt);
      r_walk    <= (w_state_nxt == WALK_PH);
    end
  end

  assign PED_ACK = r_ped_ack;
  assign MAIN_LT = r_main_lt;
  assign SIDE_LT = r_side_lt;
  assign WALK    = r_walk;
  assign PHASE   = r_state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scenario bench for tlc_phase_scheduler: expected per-cycle phase/ack queued, then compared.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic       SIDE_CAR = 1'b0;
  logic       PED_REQ = 1'b0;
  logic       PED_ACK;
  logic [2:0] MAIN_LT;
  logic [2:0] SIDE_LT;
  logic       WALK;
  logic [2:0] PHASE;

  typedef struct packed {
    logic [2:0] phase;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;

  tlc_phase_scheduler dut (
    .CK       (CK),
    .RST      (RST),
    .SIDE_CAR (SIDE_CAR),
    .PED_REQ  (PED_REQ),
    .PED_ACK  (PED_ACK),
    .MAIN_LT  (MAIN_LT),
    .SIDE_LT  (SIDE_LT),
    .WALK     (WALK),
    .PHASE    (PHASE)
  );

  always #5 CK = ~CK;

  function automatic logic [2:0] exp_main(input logic [2:0] p);
    if (p == 3'(MAIN_G)) return 3'b001;
    if (p == 3'(MAIN_Y)) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input logic [2:0] p);
    if (p == 3'(SIDE_G)) return 3'b001;
    if (p == 3'(SIDE_Y)) return 3'b010;
    return 3'b100;
  endfunction

  task automatic push(input logic [2:0] p, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{phase: p, ack: 1'b0});
  endtask

  task automatic push_ack(input logic [2:0] p);
    sb.push_back('{phase: p, ack: 1'b1});
  endtask

  task automatic do_reset();
    RST = 1'b1; SIDE_CAR = 1'b0; PED_REQ = 1'b0;
    @(posedge CK); #1;
    RST = 1'b0;
  endtask

  // Lamp safety invariant, checked every cycle once reset has been applied.
  always @(negedge CK) begin
    if (mon_en) begin
      if (!$onehot(MAIN_LT) || !$onehot(SIDE_LT) ||
          ((MAIN_LT[1:0] != 2'b00) && (SIDE_LT[1:0] != 2'b00)) ||
          (WALK && ((MAIN_LT[1:0] != 2'b00) || (SIDE_LT[1:0] != 2'b00)))) begin
        n_miss++;
        $display("FAIL lamp_safety t=%0t: got main=%b side=%b walk=%b, want one-hot, no conflicting G/Y",
                 $time, MAIN_LT, SIDE_LT, WALK);
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    int   n;
    RST = 1'b1; SIDE_CAR = 1'b1; PED_REQ = 1'b1;
    push(ALLRED_B, 3);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL reset tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
      mon_en = 1'b1;
    end
    RST = 1'b0; SIDE_CAR = 1'b0; PED_REQ = 1'b0;
  endtask

  task automatic test_idle();
    exp_t e;
    int   n;
    push(ALLRED_B, 1); push(MAIN_G, 100);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL idle tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
    end
  endtask

  task automatic test_side_cycle();
    exp_t e;
    int   n;
    do_reset();
    SIDE_CAR = 1'b1;
    push(ALLRED_B, 1); push(MAIN_G, 8); push(MAIN_Y, 3); push(ALLRED_A, 2);
    push(SIDE_G, 10); push(SIDE_Y, 3); push(ALLRED_B, 2); push(MAIN_G, 1);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL side_cycle tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
    end
    SIDE_CAR = 1'b0;
  endtask

  task automatic test_ped_walk();
    exp_t e;
    int   n;
    do_reset();
    push(ALLRED_B, 1); push(MAIN_G, 3); push_ack(MAIN_G); push(MAIN_G, 4);
    push(MAIN_Y, 3); push(ALLRED_A, 2); push(WALK_PH, 6); push(ALLRED_B, 2); push(MAIN_G, 10);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL ped_walk tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
      if (i == 3) PED_REQ = 1'b1;
      if (i == 4) PED_REQ = 1'b0;
    end
  endtask

  task automatic test_ped_and_side();
    exp_t e;
    int   n;
    do_reset();
    SIDE_CAR = 1'b1; PED_REQ = 1'b1;
    push_ack(ALLRED_B); push(MAIN_G, 8); push(MAIN_Y, 3); push(ALLRED_A, 2);
    push(WALK_PH, 6); push(SIDE_G, 1); push_ack(SIDE_G); push(SIDE_G, 8);
    push(SIDE_Y, 3); push(ALLRED_B, 2); push(MAIN_G, 1);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL ped_and_side tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
      if (i == 0)  PED_REQ = 1'b0;
      if (i == 15) PED_REQ = 1'b1;
      if (i == 21) PED_REQ = 1'b0;
    end
    SIDE_CAR = 1'b0;
  endtask

  task automatic test_side_early_exit();
    exp_t e;
    int   n;
    do_reset();
    SIDE_CAR = 1'b1;
    push(ALLRED_B, 1); push(MAIN_G, 8); push(MAIN_Y, 3); push(ALLRED_A, 2);
    push(SIDE_G, 8); push(SIDE_Y, 3); push(ALLRED_B, 2); push(MAIN_G, 3);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL side_early tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
      if (i == 17) SIDE_CAR = 1'b0;
    end
  endtask

  task automatic test_reset_mid_phase();
    exp_t e;
    int   n;
    do_reset();
    SIDE_CAR = 1'b1;
    push(ALLRED_B, 1); push(MAIN_G, 8); push(MAIN_Y, 3); push(ALLRED_A, 2);
    push(SIDE_G, 1); push_ack(SIDE_G); push(SIDE_G, 4);
    push(ALLRED_B, 2); push(MAIN_G, 10);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL reset_mid tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
      if (i == 14) PED_REQ = 1'b1;
      if (i == 15) PED_REQ = 1'b0;
      if (i == 19) RST = 1'b1;
      if (i == 20) begin RST = 1'b0; SIDE_CAR = 1'b0; end
    end
  endtask

  task automatic test_timer_saturate();
    exp_t e;
    int   n;
    do_reset();
    push(ALLRED_B, 1); push(MAIN_G, 259); push(MAIN_Y, 3); push(ALLRED_A, 2); push(SIDE_G, 1);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge CK); #1;
      e = sb.pop_front(); n_vec++;
      if ({PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK} !==
          {e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack}) begin
        n_miss++;
        $display("FAIL saturate tick %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                 i, PHASE, MAIN_LT, SIDE_LT, WALK, PED_ACK, e.phase, exp_main(e.phase), exp_side(e.phase), e.phase == 3'(WALK_PH), e.ack);
      end
      if (i == 259) SIDE_CAR = 1'b1;
    end
    SIDE_CAR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_side_cycle();
    test_ped_walk();
    test_ped_and_side();
    test_side_early_exit();
    test_reset_mid_phase();
    test_timer_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
